// File: rtl/code_lock_ctrl.sv
// Code lock: DIGITS two-bit digits are checked one per enter strobe against a
// reprogrammable code through one shared eq2 comparator, with timed unlock and fail lockout.

module eq2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);
  assign eq = (a[1] ~^ b[1]) & (a[0] ~^ b[0]);
endmodule

module code_lock_ctrl #(
  parameter int                  DIGITS      = 4,
  parameter logic [2*DIGITS-1:0] CODE        = 8'hE4,
  parameter int                  OPEN_CYCLES = 8,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] digit,
  input  logic       enter,
  input  logic       lock,
  input  logic       prog,
  output logic       ledpin,
  output logic       error,
  output logic       lockout,
  output logic       prog_active,
  output logic [2:0] progress
);
  localparam int       TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int       TW   = $clog2(TMAX + 1);
  localparam bit [2:0] LAST = 3'(DIGITS - 1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_PROG    = 3'd5
  } state_t;

  state_t                state_reg;
  logic [2*DIGITS-1:0]   code_reg;
  logic [3:0]            fail_cnt_reg;
  logic [TW-1:0]         timer_reg;
  logic                  mismatch_reg;
  logic                  digit_eq;
  logic [1:0]            code_digit [8];

  // Padded to 8 entries so the 3-bit progress count indexes it without truncation.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      if (gi < DIGITS) begin : g_used
        assign code_digit[gi] = code_reg[2*gi +: 2];
      end else begin : g_unused
        assign code_digit[gi] = 2'b00;
      end
    end
  endgenerate

  eq2 u_eq2 (
    .a  (digit),
    .b  (code_digit[progress]),
    .eq (digit_eq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_ENTRY;
      code_reg     <= CODE;
      progress     <= '0;
      fail_cnt_reg <= '0;
      timer_reg    <= '0;
      mismatch_reg <= 1'b0;
      ledpin       <= 1'b0;
      error        <= 1'b0;
      lockout      <= 1'b0;
      prog_active  <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state_reg)
        ST_ENTRY: begin
          if (enter) begin
            if (!digit_eq) mismatch_reg <= 1'b1;
            progress <= progress + 3'd1;
            if (progress == LAST) state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          progress     <= '0;
          mismatch_reg <= 1'b0;
          if (mismatch_reg) begin
            state_reg <= ST_FAIL;
            error     <= 1'b1;
            if (fail_cnt_reg != 4'(MAX_FAIL)) fail_cnt_reg <= fail_cnt_reg + 4'd1;
          end else begin
            state_reg    <= ST_OPEN;
            ledpin       <= 1'b1;
            fail_cnt_reg <= '0;
            timer_reg    <= TW'(OPEN_CYCLES);
          end
        end
        ST_FAIL: begin
          if (fail_cnt_reg == 4'(MAX_FAIL)) begin
            state_reg <= ST_LOCKOUT;
            lockout   <= 1'b1;
            timer_reg <= TW'(LOCK_CYCLES);
          end else begin
            state_reg <= ST_ENTRY;
          end
        end
        ST_LOCKOUT: begin
          timer_reg <= timer_reg - TW'(1);
          if (timer_reg == TW'(1)) begin
            state_reg    <= ST_ENTRY;
            lockout      <= 1'b0;
            fail_cnt_reg <= '0;
          end
        end
        ST_OPEN: begin
          timer_reg <= timer_reg - TW'(1);
          // lock beats prog, and an explicit request beats the timeout
          if (lock) begin
            state_reg <= ST_ENTRY;
            ledpin    <= 1'b0;
          end else if (prog) begin
            state_reg   <= ST_PROG;
            ledpin      <= 1'b0;
            prog_active <= 1'b1;
            progress    <= '0;
          end else if (timer_reg == TW'(1)) begin
            state_reg <= ST_ENTRY;
            ledpin    <= 1'b0;
          end
        end
        ST_PROG: begin
          if (lock) begin
            state_reg   <= ST_ENTRY;
            prog_active <= 1'b0;
            progress    <= '0;
          end else if (enter) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (progress == 3'(i)) code_reg[2*i +: 2] <= digit;
            end
            if (progress == LAST) begin
              state_reg   <= ST_ENTRY;
              prog_active <= 1'b0;
              progress    <= '0;
            end else begin
              progress <= progress + 3'd1;
            end
          end
        end
        default: state_reg <= ST_ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios plus random strobes, every cycle
// compared against a timestamp-based model of when each output must be high.

module tb_code_lock_ctrl;
  localparam int       DIGITS      = 4;
  localparam bit [7:0] CODE        = 8'hE4;
  localparam int       OPEN_CYCLES = 8;
  localparam int       MAX_FAIL    = 3;
  localparam int       LOCK_CYCLES = 16;

  // stimulus word: {reset, enter, digit[1:0], lock, prog}
  localparam bit [5:0] S_IDLE = 6'b000000;
  localparam bit [5:0] S_RST  = 6'b100000;
  localparam bit [5:0] S_LOCK = 6'b000010;
  localparam bit [5:0] S_PROG = 6'b000001;
  localparam bit [5:0] S_BOTH = 6'b000011;

  logic       clk = 1'b0;
  logic       reset, enter, lock, prog;
  logic [1:0] digit;
  logic       ledpin, error, lockout, prog_active;
  logic [2:0] progress;

  int vectors     = 0;
  int miscompares = 0;

  code_lock_ctrl #(
    .DIGITS(DIGITS), .CODE(CODE), .OPEN_CYCLES(OPEN_CYCLES),
    .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .digit(digit), .enter(enter), .lock(lock), .prog(prog),
    .ledpin(ledpin), .error(error), .lockout(lockout), .prog_active(prog_active),
    .progress(progress)
  );

  always #5 clk = ~clk;

  // Reference model: edge numbers at which each output is due, plus the code and entries.
  int edge_n = 0;
  int code_m [DIGITS];
  int entered [$];
  int open_first, open_last, err_edge, lo_first, lo_last, ignore_until, final_edge;
  int prog_pos, fails;
  bit prog_mode;
  logic [5:0] stim [$];

  function automatic void model_reset();
    for (int k = 0; k < DIGITS; k++) code_m[k] = int'((CODE >> (2*k)) & 8'h3);
    entered.delete();
    open_first = -10; open_last = -10; err_edge = -10;
    lo_first = -10; lo_last = -10; final_edge = -10;
    ignore_until = edge_n;
    prog_mode = 1'b0; prog_pos = 0; fails = 0;
  endfunction

  function automatic void model_step(input logic [5:0] s);
    int  n;
    bit  ok;
    n = edge_n;
    if (s[5]) begin
      model_reset();
    end else if (n <= ignore_until) begin
      // verdict, fail and lockout cycles swallow all strobes
    end else if (n - 1 >= open_first && n - 1 <= open_last) begin
      if (s[1]) open_last = n - 1;
      else if (s[0]) begin
        open_last = n - 1; prog_mode = 1'b1; prog_pos = 0;
      end
    end else if (prog_mode) begin
      if (s[1]) begin
        prog_mode = 1'b0; prog_pos = 0;
      end else if (s[4]) begin
        code_m[prog_pos] = int'(s[3:2]);
        prog_pos++;
        if (prog_pos == DIGITS) begin prog_mode = 1'b0; prog_pos = 0; end
      end
    end else if (s[4]) begin
      entered.push_back(int'(s[3:2]));
      if (entered.size() == DIGITS) begin
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) if (entered[k] != code_m[k]) ok = 1'b0;
        entered.delete();
        final_edge = n;
        if (ok) begin
          fails = 0; open_first = n + 1; open_last = n + OPEN_CYCLES; ignore_until = n + 1;
        end else begin
          fails = (fails < MAX_FAIL) ? fails + 1 : MAX_FAIL;
          err_edge = n + 1; ignore_until = n + 2;
          if (fails == MAX_FAIL) begin
            lo_first = n + 2; lo_last = n + 1 + LOCK_CYCLES;
            ignore_until = n + 2 + LOCK_CYCLES; fails = 0;
          end
        end
      end
    end
  endfunction

  function automatic logic [6:0] expected();
    logic [2:0] p;
    if (edge_n == final_edge) p = 3'(DIGITS % 8);
    else if (prog_mode)      p = 3'(prog_pos);
    else                     p = 3'(entered.size());
    return {(edge_n >= open_first && edge_n <= open_last), (edge_n == err_edge),
            (edge_n >= lo_first && edge_n <= lo_last), prog_mode, p};
  endfunction

  function automatic logic [6:0] observed();
    return {ledpin, error, lockout, prog_active, progress};
  endfunction

  task automatic apply(input logic [5:0] s);
    reset = s[5]; enter = s[4]; digit = s[3:2]; lock = s[1]; prog = s[0];
    @(posedge clk);
    edge_n++;
    model_step(s);
    #1;
  endtask

  function automatic void push_idle(input int n);
    repeat (n) stim.push_back(S_IDLE);
  endfunction

  // Each digit strobe is followed by an idle cycle.
  function automatic void push_code(input logic [7:0] c);
    for (int k = 0; k < DIGITS; k++) begin
      stim.push_back({2'b01, c[2*k +: 2], 2'b00});
      stim.push_back(S_IDLE);
    end
  endfunction

  task automatic test_reset();
    stim.delete();
    stim.push_back(S_RST); stim.push_back(S_RST); push_idle(2);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL reset_model edge %0d got %b want %b", edge_n, observed(), expected());
      end
      vectors++;
      if (observed() !== 7'b0) begin
        miscompares++;
        $display("FAIL reset_outputs edge %0d got %b want 0000000", edge_n, observed());
      end
    end
  endtask

  task automatic test_correct_code();
    int led_cnt = 0, err_cnt = 0, last_enter = 0, first_led = -1;
    stim.delete();
    stim.push_back(S_RST); push_code(CODE); push_idle(12);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL correct_code edge %0d got %b want %b", edge_n, observed(), expected());
      end
      if (stim[i][4]) last_enter = edge_n;
      if (ledpin === 1'b1) begin
        led_cnt++;
        if (first_led < 0) first_led = edge_n;
      end
      if (error === 1'b1) err_cnt++;
    end
    vectors++;
    if (led_cnt !== OPEN_CYCLES || err_cnt !== 0 || first_led - last_enter !== 1) begin
      miscompares++;
      $display("FAIL correct_code_timing got led=%0d err=%0d delay=%0d want led=%0d err=0 delay=1",
               led_cnt, err_cnt, first_led - last_enter, OPEN_CYCLES);
    end
  endtask

  task automatic test_wrong_digit();
    int led_cnt = 0, err_cnt = 0;
    stim.delete();
    stim.push_back(S_RST); push_code(8'hEC); push_idle(6);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL wrong_digit edge %0d got %b want %b", edge_n, observed(), expected());
      end
      if (ledpin === 1'b1) led_cnt++;
      if (error === 1'b1) err_cnt++;
    end
    vectors++;
    if (led_cnt !== 0 || err_cnt !== 1 || progress !== 3'd0) begin
      miscompares++;
      $display("FAIL wrong_digit_summary got led=%0d err=%0d progress=%0d want led=0 err=1 progress=0",
               led_cnt, err_cnt, progress);
    end
  endtask

  task automatic test_lockout();
    int led_cnt = 0, err_cnt = 0, lo_cnt = 0;
    stim.delete();
    stim.push_back(S_RST);
    repeat (3) begin push_code(8'hEC); push_idle(3); end
    push_code(CODE); push_idle(20); push_code(CODE); push_idle(10);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL lockout edge %0d got %b want %b", edge_n, observed(), expected());
      end
      if (ledpin === 1'b1) led_cnt++;
      if (error === 1'b1) err_cnt++;
      if (lockout === 1'b1) lo_cnt++;
    end
    vectors++;
    if (lo_cnt !== LOCK_CYCLES || err_cnt !== 3 || led_cnt !== OPEN_CYCLES) begin
      miscompares++;
      $display("FAIL lockout_summary got lockout=%0d err=%0d led=%0d want lockout=%0d err=3 led=%0d",
               lo_cnt, err_cnt, led_cnt, LOCK_CYCLES, OPEN_CYCLES);
    end
  endtask

  task automatic test_lock_priority();
    stim.delete();
    stim.push_back(S_RST); push_code(CODE); push_idle(2); stim.push_back(S_BOTH); push_idle(3);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL lock_priority edge %0d got %b want %b", edge_n, observed(), expected());
      end
      if (stim[i] == S_BOTH) begin
        vectors++;
        if (ledpin !== 1'b0 || prog_active !== 1'b0) begin
          miscompares++;
          $display("FAIL lock_wins got ledpin=%b prog_active=%b want 0 0", ledpin, prog_active);
        end
      end
    end
  endtask

  task automatic test_reprogram();
    int pa_cnt = 0, err_cnt = 0, led_rise = 0;
    logic led_prev = 1'b0;
    stim.delete();
    stim.push_back(S_RST); push_code(CODE); push_idle(2); stim.push_back(S_PROG);
    push_code(8'h4F); push_idle(2);
    push_code(CODE); push_idle(4);
    push_code(8'h4F); push_idle(10);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL reprogram edge %0d got %b want %b", edge_n, observed(), expected());
      end
      if (prog_active === 1'b1) pa_cnt++;
      if (error === 1'b1) err_cnt++;
      if (ledpin === 1'b1 && led_prev === 1'b0) led_rise++;
      led_prev = ledpin;
    end
    vectors++;
    if (pa_cnt !== 7 || err_cnt !== 1 || led_rise !== 2) begin
      miscompares++;
      $display("FAIL reprogram_summary got prog_active=%0d err=%0d opens=%0d want 7 1 2",
               pa_cnt, err_cnt, led_rise);
    end
  endtask

  task automatic test_reset_mid_prog();
    int err_cnt = 0, led_rise = 0;
    logic led_prev = 1'b0;
    stim.delete();
    stim.push_back(S_RST); push_code(CODE); push_idle(1); stim.push_back(S_PROG);
    stim.push_back(6'b011100); stim.push_back(S_IDLE); stim.push_back(6'b011100);
    stim.push_back(S_RST); push_idle(2); push_code(CODE); push_idle(10);
    foreach (stim[i]) begin
      apply(stim[i]);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL reset_mid_prog edge %0d got %b want %b", edge_n, observed(), expected());
      end
      if (stim[i] == S_RST && i > 0) begin
        vectors++;
        if (observed() !== 7'b0) begin
          miscompares++;
          $display("FAIL reset_mid_prog_outputs got %b want 0000000", observed());
        end
      end
      if (error === 1'b1) err_cnt++;
      if (ledpin === 1'b1 && led_prev === 1'b0) led_rise++;
      led_prev = ledpin;
    end
    vectors++;
    if (err_cnt !== 0 || led_rise !== 2) begin
      miscompares++;
      $display("FAIL reset_mid_prog_summary got err=%0d opens=%0d want 0 2", err_cnt, led_rise);
    end
  endtask

  task automatic test_random();
    logic [5:0] s;
    logic [1:0] d;
    int r, idx;
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 199);
      idx = prog_mode ? prog_pos : entered.size();
      // mostly follow the current code so that opens, lockouts and reprograms all occur
      d   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'(code_m[idx]);
      if (i == 0 || r == 0) s = S_RST;
      else if (r < 10)      s = S_LOCK;
      else if (r < 18)      s = S_PROG;
      else if (r < 21)      s = S_BOTH;
      else if (r < 110)     s = {2'b01, d, 2'b00};
      else                  s = S_IDLE;
      apply(s);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL random edge %0d stim %b got %b want %b", edge_n, s, observed(), expected());
      end
    end
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; digit = 2'b00; lock = 1'b0; prog = 1'b0;
    test_reset();
    test_correct_code();
    test_wrong_digit();
    test_lockout();
    test_lock_priority();
    test_reprogram();
    test_reset_mid_prog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
